// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet transmit arbiter.
//   tx_state_e      : arbiter FSM state encoding
//   ARP_TYPE_REQ    : arp_rx_type/arp_tx_type value for an ARP request
//   ARP_TYPE_REPLY  : arp_rx_type/arp_tx_type value for an ARP reply
//   DEFAULT_IFG_CYC : default inter-frame gap in transmit clocks
package eth_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARP_TX = 2'd1,
        ST_UDP_TX = 2'd2,
        ST_IFG    = 2'd3
    } tx_state_e;

    localparam logic ARP_TYPE_REQ   = 1'b0;
    localparam logic ARP_TYPE_REPLY = 1'b1;

    localparam int unsigned DEFAULT_IFG_CYC = 12;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first asserted request at or
// above ptr, wrapping from N-1 back to 0.
//   req   : request vector, one bit per requester
//   ptr   : index where the search starts
//   valid : at least one request is asserted
//   idx   : index of the selected requester (0 when valid is low)
module rr_pick #(
    parameter  int unsigned N  = 2,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

    logic [PW-1:0] w_cand;

    // Walk the requesters in priority order starting at ptr; first hit wins.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_cand = PW'((32'(ptr) + i) % N);
            if (!valid && req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// GMII transmit arbiter: merges the ARP responder and NUM_CH UDP sources onto a
// single GMII transmit bus, granting whole frames only. A pending ARP reply
// wins at every frame boundary; UDP sources share the bus round-robin. Every
// frame is followed by IFG_CYC idle cycles, and a grant held for TIMEOUT_CYC
// cycles without a done pulse is forcibly released (0 disables this).
//   clk, rst_n          : transmit clock, asynchronous active-low reset
//   arp_rx_done/_type   : received ARP packet strobe and its type
//   arp_tx_en/_type     : start pulse and type for the ARP transmitter
//   arp_tx_done         : ARP frame finished
//   arp_gmii_tx_en/txd  : ARP transmit stream
//   udp_req/_grant/_done: per-source request, one-hot grant, end-of-frame
//   udp_gmii_tx_en/txd  : per-source streams, source i at [i*DATA_W +: DATA_W]
//   gmii_tx_en/txd      : merged stream, selected input delayed by one clock
//   timeout_err         : pulse when a grant is force-released
module eth_tx_arbiter
    import eth_tx_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned IFG_CYC     = DEFAULT_IFG_CYC,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arp_rx_done,
    input  logic                     arp_rx_type,
    output logic                     arp_tx_en,
    output logic                     arp_tx_type,
    input  logic                     arp_tx_done,
    input  logic                     arp_gmii_tx_en,
    input  logic [DATA_W-1:0]        arp_gmii_txd,
    input  logic [NUM_CH-1:0]        udp_req,
    output logic [NUM_CH-1:0]        udp_grant,
    input  logic [NUM_CH-1:0]        udp_done,
    input  logic [NUM_CH-1:0]        udp_gmii_tx_en,
    input  logic [NUM_CH*DATA_W-1:0] udp_gmii_txd,
    output logic                     gmii_tx_en,
    output logic [DATA_W-1:0]        gmii_txd,
    output logic                     timeout_err
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned IFG_W = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    tx_state_e         r_state;
    logic              r_arp_pend;
    logic              r_arp_tx_en;
    logic              r_timeout_err;
    logic              r_tx_en;
    logic [DATA_W-1:0] r_txd;
    logic [NUM_CH-1:0] r_grant;
    logic [CH_W-1:0]   r_cur;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [TO_W-1:0]   r_cnt;
    logic [IFG_W-1:0]  r_ifg;

    logic              w_pick_valid;
    logic [CH_W-1:0]   w_pick_idx;
    logic              w_timeout;
    logic              w_cur_done;
    logic              w_ifg_last;
    logic [CH_W-1:0]   w_next_ptr;

    rr_pick #(
        .N (NUM_CH)
    ) u_rr_pick (
        .req   (udp_req),
        .ptr   (r_rr_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // r_cnt counts cycles spent in the current grant, starting at 0 on entry.
    assign w_timeout  = (TIMEOUT_CYC != 0) && (r_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign w_cur_done = udp_done[r_cur];
    assign w_ifg_last = (r_ifg == IFG_W'(IFG_CYC - 1));
    assign w_next_ptr = (r_cur == CH_W'(NUM_CH - 1)) ? '0 : r_cur + CH_W'(1);

    // Arbitration FSM, pending-ARP flag and registered output mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_arp_pend    <= 1'b0;
            r_arp_tx_en   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_tx_en       <= 1'b0;
            r_txd         <= '0;
            r_grant       <= '0;
            r_cur         <= '0;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
            r_ifg         <= '0;
        end else begin
            r_arp_tx_en   <= 1'b0;
            r_timeout_err <= 1'b0;

            // Requests arriving while one is already pending merge into it.
            if (arp_rx_done && (arp_rx_type == ARP_TYPE_REQ)) begin
                r_arp_pend <= 1'b1;
            end

            // Output mux follows the state of the cycle the data was presented in.
            case (r_state)
                ST_ARP_TX: begin
                    r_tx_en <= arp_gmii_tx_en;
                    r_txd   <= arp_gmii_txd;
                end
                ST_UDP_TX: begin
                    r_tx_en <= udp_gmii_tx_en[r_cur];
                    r_txd   <= udp_gmii_txd[32'(r_cur) * DATA_W +: DATA_W];
                end
                default: begin
                    r_tx_en <= 1'b0;
                    r_txd   <= '0;
                end
            endcase

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_ifg <= '0;
                    if (r_arp_pend) begin
                        // Clearing here wins over a same-cycle request: that
                        // request is answered by the reply about to go out.
                        r_state     <= ST_ARP_TX;
                        r_arp_tx_en <= 1'b1;
                        r_arp_pend  <= 1'b0;
                    end else if (w_pick_valid) begin
                        r_state <= ST_UDP_TX;
                        r_cur   <= w_pick_idx;
                        r_grant <= NUM_CH'(1) << w_pick_idx;
                    end
                end
                ST_ARP_TX: begin
                    if (arp_tx_done) begin
                        r_state <= ST_IFG;
                    end else if (w_timeout) begin
                        r_state       <= ST_IFG;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                ST_UDP_TX: begin
                    // A done in the timeout cycle is a normal completion.
                    if (w_cur_done || w_timeout) begin
                        r_state       <= ST_IFG;
                        r_grant       <= '0;
                        r_rr_ptr      <= w_next_ptr;
                        r_timeout_err <= !w_cur_done;
                    end else begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                ST_IFG: begin
                    if (w_ifg_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ifg <= r_ifg + IFG_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign arp_tx_en   = r_arp_tx_en;
    assign arp_tx_type = ARP_TYPE_REPLY;
    assign udp_grant   = r_grant;
    assign gmii_tx_en  = r_tx_en;
    assign gmii_txd    = r_txd;
    assign timeout_err = r_timeout_err;

endmodule
